// File: rtl/mem_io_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_io_bridge_pkg
//  Brief    : Shared definitions for the memory/IO bridge: access-size
//             encoding, FSM state type and small decode helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_io_bridge_pkg;

   // Access-size encoding carried on req_size
   localparam logic [1:0] c_sz_byte  = 2'b00;   // byte, sign-extended on load
   localparam logic [1:0] c_sz_word  = 2'b01;   // 32-bit word
   localparam logic [1:0] c_sz_byteu = 2'b10;   // byte, zero-extended on load
   localparam logic [1:0] c_sz_half  = 2'b11;   // halfword, sign-extended on load

   // Bridge control states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MEM  = 2'd1,
      ST_IO   = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   // A word must sit on a 4-byte boundary, a half on a 2-byte boundary
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      logic w_mis;
      w_mis = 1'b0;
      if (size == c_sz_word)
         w_mis = (lane != 2'b00);
      else if (size == c_sz_half)
         w_mis = lane[0];
      return w_mis;
   endfunction

   // Byte strobes for an aligned access at the given lane
   function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lane);
      logic [3:0] w_be;
      case (size)
         c_sz_byte, c_sz_byteu: w_be = 4'b0001 << lane;
         c_sz_half:             w_be = lane[1] ? 4'b1100 : 4'b0011;
         default:               w_be = 4'b1111;
      endcase
      return w_be;
   endfunction

   // Replicate right-aligned store data across every lane it could land in
   function automatic logic [31:0] replicate_store(input logic [1:0] size, input logic [31:0] data);
      logic [31:0] w_rep;
      case (size)
         c_sz_byte, c_sz_byteu: w_rep = {4{data[7:0]}};
         c_sz_half:             w_rep = {2{data[15:0]}};
         default:               w_rep = data;
      endcase
      return w_rep;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_io_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_io_bridge_if
//  Brief    : Request/response, data-RAM and IO-channel signal bundle of the
//             bridge. "slave" is the bridge view, "master" the environment.
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_io_bridge_if #(
   parameter int ADDR_W = 14,
   parameter int IO_CH  = 4,
   parameter int IO_W   = 16
);
   // Request / response
   logic                    req_valid;
   logic                    req_ready;
   logic                    req_we;
   logic [1:0]              req_size;
   logic [ADDR_W-1:0]       req_addr;
   logic [31:0]             req_wdata;
   logic                    resp_valid;
   logic [31:0]             resp_rdata;
   logic                    resp_err;
   // Data RAM
   logic                    mem_en;
   logic [3:0]              mem_be;
   logic [ADDR_W-3:0]       mem_addr;
   logic [31:0]             mem_wdata;
   logic [31:0]             mem_rdata;
   // IO channels
   logic [IO_CH-1:0]        io_sel;
   logic                    io_we;
   logic [IO_W-1:0]         io_wdata;
   logic [IO_CH*IO_W-1:0]   io_rdata;
   logic [IO_CH-1:0]        io_ack;

   modport slave (
      input  req_valid, req_we, req_size, req_addr, req_wdata,
      input  mem_rdata, io_rdata, io_ack,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_en, mem_be, mem_addr, mem_wdata,
      output io_sel, io_we, io_wdata
   );

   modport master (
      output req_valid, req_we, req_size, req_addr, req_wdata,
      output mem_rdata, io_rdata, io_ack,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_en, mem_be, mem_addr, mem_wdata,
      input  io_sel, io_we, io_wdata
   );

endinterface
`default_nettype wire

// File: rtl/mem_io_bridge_load_align.sv
`default_nettype none
// ============================================================================
//  Module   : load_align
//  Brief    : Picks the addressed lane out of a 32-bit RAM word and extends
//             it to 32 bits according to the access size.
//  Revision : 1.0 - initial release
// ============================================================================
module load_align
   import mem_io_bridge_pkg::*;
(
   input  wire logic [31:0] i_rdata,
   input  wire logic [1:0]  i_lane,
   input  wire logic [1:0]  i_size,
   output logic [31:0]      o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Lane selection followed by sign/zero extension
   always_comb begin
      w_byte = i_rdata[7:0];
      w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
      case (i_lane)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      case (i_size)
         c_sz_byte:  o_data = {{24{w_byte[7]}}, w_byte};
         c_sz_byteu: o_data = {24'h000000, w_byte};
         c_sz_half:  o_data = {{16{w_half[15]}}, w_half};
         default:    o_data = i_rdata;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : mem_io_bridge
//  Brief    : Single-outstanding bridge from a load/store request port to a
//             synchronous data RAM (below IO_BASE) or to IO_CH handshaked IO
//             channels (at/above IO_BASE), with alignment and ack-timeout
//             error reporting.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_io_bridge
   import mem_io_bridge_pkg::*;
#(
   parameter int                ADDR_W  = 14,
   parameter int                IO_CH   = 4,
   parameter int                IO_W    = 16,
   parameter logic [ADDR_W-1:0] IO_BASE = 14'h3C00,
   parameter int                TIMEOUT = 15
)(
   input  wire logic        clk,
   input  wire logic        rst_n,
   mem_io_bridge_if.slave   bus
);

   localparam int                 c_cnt_w    = $clog2(TIMEOUT + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

   state_t               r_state;
   state_t               w_next;

   // Captured request
   logic                 r_we;
   logic [1:0]           r_size;
   logic [ADDR_W-1:0]    r_addr;
   logic [31:0]          r_wdata;
   logic                 r_is_io;
   logic [IO_CH-1:0]     r_ch_oh;

   // Access progress and response
   logic                 r_err_pend;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [31:0]          r_io_rdata;
   logic                 r_resp_valid;
   logic                 r_resp_err;
   logic [31:0]          r_resp_rdata;

   logic                 w_accept;
   logic                 w_req_io;
   logic                 w_req_mis;
   logic [IO_CH-1:0]     w_req_ch_oh;
   logic                 w_req_ch_ok;
   logic                 w_io_ack;
   logic [IO_W-1:0]      w_io_data;
   logic [31:0]          w_io_sext;
   logic [31:0]          w_load_data;

   assign w_accept    = bus.req_valid && (r_state == ST_IDLE);
   assign w_req_io    = (bus.req_addr >= IO_BASE);
   assign w_req_mis   = is_misaligned(bus.req_size, bus.req_addr[1:0]);
   assign w_req_ch_ok = |w_req_ch_oh;
   assign w_io_ack    = |(bus.io_ack & r_ch_oh);
   assign w_io_sext   = {{(32-IO_W){w_io_data[IO_W-1]}}, w_io_data};

   // Channel decode from addr[7:4]; an empty one-hot marks a non-existent channel
   always_comb begin
      w_req_ch_oh = '0;
      for (int i = 0; i < IO_CH; i++) begin
         w_req_ch_oh[i] = (bus.req_addr[7:4] == 4'(i));
      end
   end

   // Read-data mux for the channel selected by the captured one-hot
   always_comb begin
      w_io_data = '0;
      for (int i = 0; i < IO_CH; i++) begin
         if (r_ch_oh[i])
            w_io_data = w_io_data | bus.io_rdata[i*IO_W +: IO_W];
      end
   end

   load_align u_load_align (
      .i_rdata (bus.mem_rdata),
      .i_lane  (r_addr[1:0]),
      .i_size  (r_size),
      .o_data  (w_load_data)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   // Next-state decode; alignment errors take precedence over address decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_req_mis)
                  w_next = ST_RESP;
               else if (w_req_io)
                  w_next = w_req_ch_ok ? ST_IO : ST_RESP;
               else
                  w_next = ST_MEM;
            end
         end
         ST_MEM:  w_next = ST_RESP;
         ST_IO: begin
            // An ack in the final counted cycle still completes normally
            if (w_io_ack || (r_cnt == c_cnt_last))
               w_next = ST_RESP;
         end
         ST_RESP: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Request capture, IO wait counting and registered response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we         <= 1'b0;
         r_size       <= c_sz_word;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_is_io      <= 1'b0;
         r_ch_oh      <= '0;
         r_err_pend   <= 1'b0;
         r_cnt        <= '0;
         r_io_rdata   <= '0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
      end else begin
         r_resp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_we       <= bus.req_we;
                  r_size     <= bus.req_size;
                  r_addr     <= bus.req_addr;
                  r_wdata    <= bus.req_wdata;
                  r_is_io    <= w_req_io;
                  r_ch_oh    <= w_req_ch_oh;
                  r_err_pend <= w_req_mis || (w_req_io && !w_req_ch_ok);
                  r_cnt      <= '0;
               end
            end
            ST_IO: begin
               r_cnt <= r_cnt + c_cnt_w'(1);
               if (w_io_ack)
                  r_io_rdata <= w_io_sext;
               else if (r_cnt == c_cnt_last)
                  r_err_pend <= 1'b1;
            end
            ST_RESP: begin
               r_resp_valid <= 1'b1;
               r_resp_err   <= r_err_pend;
               if (r_err_pend || r_we)
                  r_resp_rdata <= '0;
               else if (r_is_io)
                  r_resp_rdata <= r_io_rdata;
               else
                  r_resp_rdata <= w_load_data;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready  = (r_state == ST_IDLE);
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_err   = r_resp_err;
   assign bus.resp_rdata = r_resp_rdata;

   assign bus.mem_en     = (r_state == ST_MEM);
   assign bus.mem_be     = ((r_state == ST_MEM) && r_we) ? byte_enables(r_size, r_addr[1:0]) : 4'b0000;
   assign bus.mem_addr   = r_addr[ADDR_W-1:2];
   assign bus.mem_wdata  = replicate_store(r_size, r_wdata);

   assign bus.io_sel     = (r_state == ST_IO) ? r_ch_oh : '0;
   assign bus.io_we      = (r_state == ST_IO) && r_we;
   assign bus.io_wdata   = r_wdata[IO_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_mem_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_io_bridge
//  Brief    : Directed scoreboard bench for mem_io_bridge with a one-cycle
//             RAM model and a programmable-delay IO responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_io_bridge;
   import mem_io_bridge_pkg::*;

   localparam int ADDR_W  = 14;
   localparam int IO_CH   = 8;
   localparam int IO_W    = 16;
   localparam int TIMEOUT = 15;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_io_bridge_if #(.ADDR_W(ADDR_W), .IO_CH(IO_CH), .IO_W(IO_W)) bus ();

   mem_io_bridge #(
      .ADDR_W  (ADDR_W),
      .IO_CH   (IO_CH),
      .IO_W    (IO_W),
      .IO_BASE (14'h3C00),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct { logic err; logic [31:0] rdata; int lat; int acc; } rsp_t;
   typedef struct { logic [3:0] be; logic [11:0] addr; logic [31:0] wdata; bit chk_wd; } mem_t;
   typedef struct { logic [7:0] sel; logic we; logic [15:0] wdata; int dur; } io_t;

   rsp_t rsp_q[$];
   mem_t mem_q[$];
   io_t  io_q[$];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic miss(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: expected event missing or unexpected event seen", name);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: one-cycle read latency, byte-strobed writes
   logic [31:0] ram [0:15];
   always @(posedge clk) begin
      if (!rst_n) begin
         ram[0] <= 32'h80017FFF;
         ram[1] <= 32'h1280FF00;
         ram[2] <= 32'h00000000;
         ram[3] <= 32'h00000000;
      end else if (bus.mem_en) begin
         for (int b = 0; b < 4; b++)
            if (bus.mem_be[b]) ram[bus.mem_addr[3:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
         bus.mem_rdata <= ram[bus.mem_addr[3:0]];
      end
   end

   // IO responder: acks the selected channel ack_delay+1 cycles into the access
   logic [IO_CH-1:0]      r_ack;
   logic [IO_CH-1:0]      noise_ack;
   logic [IO_CH*IO_W-1:0] io_bus_data;
   bit                    ack_en;
   int                    ack_delay;
   int                    acnt;
   always @(posedge clk) begin
      if (!rst_n || bus.io_sel == '0) begin
         acnt  <= 0;
         r_ack <= '0;
      end else begin
         acnt  <= acnt + 1;
         r_ack <= (ack_en && acnt == ack_delay - 1) ? bus.io_sel : '0;
      end
   end
   assign bus.io_ack   = r_ack | noise_ack;
   assign bus.io_rdata = io_bus_data;

   // Monitor: compares every DUT-presented event against the queued expectation
   logic [IO_CH-1:0] prev_sel = '0;
   int io_run = 0;
   int io_dur_exp = 0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.resp_valid) begin
            if (rsp_q.size() == 0) miss("unexpected_resp");
            else begin
               chk("resp_err", 32'(bus.resp_err), 32'(rsp_q[0].err));
               chk("resp_rdata", bus.resp_rdata, rsp_q[0].rdata);
               if (rsp_q[0].lat >= 0) chk("resp_latency", cyc - rsp_q[0].acc, rsp_q[0].lat);
               void'(rsp_q.pop_front());
            end
         end
         if (bus.mem_en) begin
            if (mem_q.size() == 0) miss("unexpected_mem_en");
            else begin
               chk("mem_be", 32'(bus.mem_be), 32'(mem_q[0].be));
               chk("mem_addr", 32'(bus.mem_addr), 32'(mem_q[0].addr));
               if (mem_q[0].chk_wd) chk("mem_wdata", bus.mem_wdata, mem_q[0].wdata);
               void'(mem_q.pop_front());
            end
         end
         if (bus.io_sel != '0 && prev_sel == '0) begin
            if (io_q.size() == 0) miss("unexpected_io_sel");
            else begin
               chk("io_sel", 32'(bus.io_sel), 32'(io_q[0].sel));
               chk("io_we", 32'(bus.io_we), 32'(io_q[0].we));
               if (io_q[0].we) chk("io_wdata", 32'(bus.io_wdata), 32'(io_q[0].wdata));
               io_dur_exp <= io_q[0].dur;
               void'(io_q.pop_front());
            end
            io_run <= 1;
         end else if (bus.io_sel != '0) begin
            io_run <= io_run + 1;
         end
         if (bus.io_sel == '0 && prev_sel != '0 && io_dur_exp > 0)
            chk("io_sel_cycles", io_run, io_dur_exp);
      end
      prev_sel <= bus.io_sel;
   end

   // Issue one request; the fields are scrambled right after acceptance
   task automatic do_req(input logic we, input logic [1:0] sz, input logic [13:0] addr,
                         input logic [31:0] wd, input bit want_rsp, input logic err,
                         input logic [31:0] rd, input int lat);
      @(negedge clk);
      bus.req_we    = we;
      bus.req_size  = sz;
      bus.req_addr  = addr;
      bus.req_wdata = wd;
      bus.req_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (bus.req_ready) break;
         @(negedge clk);
      end
      if (!bus.req_ready) begin
         miss("req_ready_wait");
         bus.req_valid = 1'b0;
         return;
      end
      if (want_rsp) rsp_q.push_back('{err: err, rdata: rd, lat: lat, acc: cyc});
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_we    = ~we;
      bus.req_size  = ~sz;
      bus.req_addr  = ~addr;
      bus.req_wdata = 32'hDEADBEEF;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 60; i++) begin
         if (rsp_q.size() == 0) break;
         @(negedge clk);
      end
      if (rsp_q.size() != 0) begin
         miss("resp_timeout");
         rsp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic exp_mem(input logic [3:0] be, input logic [11:0] a, input logic [31:0] wd, input bit c);
      mem_q.push_back('{be: be, addr: a, wdata: wd, chk_wd: c});
   endtask

   task automatic exp_io(input logic [7:0] sel, input logic we, input logic [15:0] wd, input int dur);
      io_q.push_back('{sel: sel, we: we, wdata: wd, dur: dur});
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_size  = 2'b00;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      noise_ack     = '0;
      ack_en        = 1'b0;
      ack_delay     = 1;
      for (int c = 0; c < IO_CH; c++) io_bus_data[c*IO_W +: IO_W] = 16'(16'h0A00 + c);
      io_bus_data[7*IO_W +: IO_W] = 16'h8001;
      io_bus_data[1*IO_W +: IO_W] = 16'h1234;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
      chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
      chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
      chk("rst_io_sel", 32'(bus.io_sel), 32'd0);
      chk("rst_io_we", 32'(bus.io_we), 32'd0);
      chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
      rst_n = 1'b1;

      // Memory loads: lane select and extension
      exp_mem(4'b0000, 12'h001, 32'h0, 1'b0);
      do_req(1'b0, c_sz_byte,  14'h0005, 32'h0, 1'b1, 1'b0, 32'hFFFFFFFF, 3); wait_done();
      exp_mem(4'b0000, 12'h001, 32'h0, 1'b0);
      do_req(1'b0, c_sz_byteu, 14'h0005, 32'h0, 1'b1, 1'b0, 32'h000000FF, 3); wait_done();
      exp_mem(4'b0000, 12'h000, 32'h0, 1'b0);
      do_req(1'b0, c_sz_half,  14'h0002, 32'h0, 1'b1, 1'b0, 32'hFFFF8001, 3); wait_done();
      exp_mem(4'b0000, 12'h000, 32'h0, 1'b0);
      do_req(1'b0, c_sz_half,  14'h0000, 32'h0, 1'b1, 1'b0, 32'h00007FFF, 3); wait_done();
      exp_mem(4'b0000, 12'h001, 32'h0, 1'b0);
      do_req(1'b0, c_sz_word,  14'h0004, 32'h0, 1'b1, 1'b0, 32'h1280FF00, 3); wait_done();

      // Stores: strobes, replication, then read back through the RAM
      exp_mem(4'b1100, 12'h001, 32'hBEEFBEEF, 1'b1);
      do_req(1'b1, c_sz_half,  14'h0006, 32'h0000BEEF, 1'b1, 1'b0, 32'h0, 3); wait_done();
      exp_mem(4'b0000, 12'h001, 32'h0, 1'b0);
      do_req(1'b0, c_sz_word,  14'h0004, 32'h0, 1'b1, 1'b0, 32'hBEEFFF00, 3); wait_done();
      exp_mem(4'b0010, 12'h002, 32'hA5A5A5A5, 1'b1);
      do_req(1'b1, c_sz_byte,  14'h0009, 32'h000000A5, 1'b1, 1'b0, 32'h0, 3); wait_done();
      exp_mem(4'b1111, 12'h003, 32'h12345678, 1'b1);
      do_req(1'b1, c_sz_word,  14'h000C, 32'h12345678, 1'b1, 1'b0, 32'h0, 3); wait_done();
      exp_mem(4'b0000, 12'h002, 32'h0, 1'b0);
      do_req(1'b0, c_sz_word,  14'h0008, 32'h0, 1'b1, 1'b0, 32'h0000A500, 3); wait_done();
      exp_mem(4'b0000, 12'h003, 32'h0, 1'b0);
      do_req(1'b0, c_sz_byte,  14'h000F, 32'h0, 1'b1, 1'b0, 32'h00000012, 3); wait_done();

      // Misaligned accesses: error, no RAM or IO strobe
      do_req(1'b0, c_sz_word,  14'h0002, 32'h0, 1'b1, 1'b1, 32'h0, 2); wait_done();
      do_req(1'b1, c_sz_half,  14'h0001, 32'hFFFF, 1'b1, 1'b1, 32'h0, 2); wait_done();
      do_req(1'b0, c_sz_word,  14'h3C71, 32'h0, 1'b1, 1'b1, 32'h0, 2); wait_done();

      // IO reads with acks on the other channels as noise
      noise_ack = 8'h7F; ack_en = 1'b1; ack_delay = 3;
      exp_io(8'h80, 1'b0, 16'h0, 0);
      do_req(1'b0, c_sz_word,  14'h3C70, 32'h0, 1'b1, 1'b0, 32'hFFFF8001, 6); wait_done();
      noise_ack = 8'hFD;
      exp_io(8'h02, 1'b0, 16'h0, 0);
      do_req(1'b0, c_sz_byte,  14'h3C10, 32'h0, 1'b1, 1'b0, 32'h00001234, 6); wait_done();

      // IO write that never gets acked: timeout
      noise_ack = 8'hFB; ack_en = 1'b0;
      exp_io(8'h04, 1'b1, 16'hC0DE, TIMEOUT);
      do_req(1'b1, c_sz_word,  14'h3C20, 32'hAAAAC0DE, 1'b1, 1'b1, 32'h0, 17); wait_done();

      // Ack in the last counted cycle wins; one cycle later is a timeout
      noise_ack = '0; ack_en = 1'b1; ack_delay = 14;
      exp_io(8'h08, 1'b0, 16'h0, TIMEOUT);
      do_req(1'b0, c_sz_word,  14'h3C30, 32'h0, 1'b1, 1'b0, 32'h00000A03, 17); wait_done();
      ack_delay = 15;
      exp_io(8'h08, 1'b0, 16'h0, TIMEOUT);
      do_req(1'b0, c_sz_word,  14'h3C30, 32'h0, 1'b1, 1'b1, 32'h0, 17); wait_done();

      // Non-existent channel
      do_req(1'b0, c_sz_word,  14'h3C80, 32'h0, 1'b1, 1'b1, 32'h0, 2); wait_done();

      // Reset during an IO wait abandons the access
      ack_en = 1'b0;
      exp_io(8'h04, 1'b1, 16'h5555, 0);
      do_req(1'b1, c_sz_word,  14'h3C20, 32'h00005555, 1'b0, 1'b0, 32'h0, -1);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_io_sel", 32'(bus.io_sel), 32'd0);
      chk("rst_mid_resp_valid", 32'(bus.resp_valid), 32'd0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("post_rst_resp_rdata", bus.resp_rdata, 32'd0);

      // Normal operation after the abandoned access
      exp_mem(4'b0000, 12'h000, 32'h0, 1'b0);
      do_req(1'b0, c_sz_word,  14'h0000, 32'h0, 1'b1, 1'b0, 32'h80017FFF, 3); wait_done();

      repeat (3) @(negedge clk);
      chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
      chk("io_q_drained", 32'(io_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_io_bridge.md
MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_W, 14: byte address width.
- IO_CH, 4: number of IO channels.
- IO_W, 16: IO data width.
- IO_BASE, 14'h3C00: first IO address; addr >= IO_BASE selects IO.
- TIMEOUT, 15: maximum wait cycles for io_ack.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1: sole clock; all state updates on its rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- req_valid, in, 1: request present.
- req_ready, out, 1: bridge accepts the request.
- req_we, in, 1: 1 = write, 0 = read.
- req_size, in, 2: 00 = byte signed, 01 = word, 10 = byte unsigned, 11 = half signed.
- req_addr, in, ADDR_W: byte address.
- req_wdata, in, 32: store data, right-aligned.
- resp_valid, out, 1: one-cycle completion pulse.
- resp_rdata, out, 32: extended load data.
- resp_err, out, 1: misaligned or timed-out access, qualified by resp_valid.
- mem_en, out, 1: data-RAM enable.
- mem_be, out, 4: byte write strobes; 0 on reads.
- mem_addr, out, ADDR_W-2: word address.
- mem_wdata, out, 32: lane-replicated store data.
- mem_rdata, in, 32: RAM data, valid one cycle after mem_en.
- io_sel, out, IO_CH: one-hot channel strobe.
- io_we, out, 1: IO write.
- io_wdata, out, IO_W: req_wdata[IO_W-1:0].
- io_rdata, in, IO_CH*IO_W: per-channel read buses, channel 0 in the LSBs.
- io_ack, in, IO_CH: per-channel completion.

Function
REQ-003 FSM states IDLE, MEM, IO, RESP; req_ready = 1 only in IDLE.
REQ-004 Handshake: request accepted when req_valid && req_ready; all request fields captured in that cycle; later input changes ignored until the next acceptance.
REQ-005 Misalignment: word with addr[1:0] != 0, or half with addr[0] != 0 -> IDLE to RESP, resp_err = 1, no mem_en and no io_sel asserted.
REQ-006 Memory decode: addr < IO_BASE -> MEM.
- mem_en held for exactly one cycle.
- mem_be: byte = 1 << addr[1:0]; half = 0011 or 1100; word = 1111.
- Next cycle: RESP.
- Memory access latency: 3 cycles from acceptance to resp_valid.
REQ-007 Load extraction: lane selected by addr[1:0], then sign- or zero-extended per req_size.
REQ-008 IO decode: addr >= IO_BASE -> IO; channel = addr[7:4].
- Channel >= IO_CH -> RESP with resp_err = 1.
- Otherwise io_sel bit held until io_ack of that channel.
REQ-009 IO read returns the selected channel's data sign-extended from IO_W to 32 bits, regardless of req_size.
REQ-010 Timeout counter:
- Cleared on entry to IO; counts cycles in IO.
- io_ack not seen after TIMEOUT cycles -> RESP with resp_err = 1; io_sel dropped.
- Ack in the same cycle as the final count wins: no error.
REQ-011 RESP lasts one cycle: resp_valid = 1, then IDLE.
- resp_rdata = 0 for writes and errors.
- resp_rdata held stable until the next RESP.
REQ-012 io_ack on non-selected channels ignored.

Reset
REQ-013 rst_n low asynchronously forces:
- State = IDLE.
- req_ready = 1 once reset is released.
- resp_valid, resp_err, mem_en, io_sel, io_we = 0.
- mem_be = 0; resp_rdata = 0; timeout counter = 0.
REQ-014 Reset mid-access abandons the access with no response.

Structure
REQ-015 Shared package holds the size encoding constants and the FSM state typedef.
REQ-016 Sub-module load_align (lane select and extension) is used for memory loads.

Verification
REQ-017 Byte-signed load, addr 0x0005, mem_rdata 0x1280FF00 -> resp_rdata 0xFFFFFFFF (lane 1 = 0xFF, sign-extended), resp_err 0, resp_valid 3 cycles after acceptance.
REQ-018 Half store, addr 0x0006, req_wdata 0x0000BEEF -> mem_be 1100, mem_wdata 0xBEEFBEEF, resp_err 0.
REQ-019 Word load, addr 0x0002 -> resp_err 1, mem_en never asserted.
REQ-020 IO read, addr 0x3C70, IO_CH 8, channel 7 acks after 4 cycles with data 0x8001 -> io_sel 0x80, resp_rdata 0xFFFF8001.
REQ-021 IO write, channel 2, io_ack never asserted -> io_sel dropped after 15 cycles, resp_err 1.
REQ-022 rst_n pulsed low during IO wait -> io_sel 0 immediately, no resp_valid, req_ready 1 after release.
